// File: rtl/efi_cfg_pkg.sv
// Shared definitions for the engine configuration commit path: register map,
// reset defaults, error codes and commit FSM encoding.
package efi_cfg_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_W    = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned BUSY_W   = 6;

    localparam int unsigned REG_MODE      = 0;
    localparam int unsigned REG_TOOTH_CNT = 1;
    localparam int unsigned REG_TOOTH_W   = 2;
    localparam int unsigned REG_MISSING   = 3;
    localparam int unsigned REG_TRIG_OFS  = 4;
    localparam int unsigned REG_QPR       = 5;
    localparam int unsigned REG_PHASE_A   = 6;
    localparam int unsigned REG_PHASE_B   = 7;
    localparam int unsigned REG_PHASE_C   = 8;
    localparam int unsigned REG_PHASE_D   = 9;
    localparam int unsigned REG_TIMING    = 10;
    localparam int unsigned REG_DWELL     = 11;
    localparam int unsigned REG_INJ_A_PW  = 12;
    localparam int unsigned REG_INJ_B_PW  = 13;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ZERO    = 3'd1,
        ERR_MISSING = 3'd2,
        ERR_GEOM    = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_ABORT   = 3'd5
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_VALIDATE  = 2'd1,
        ST_WAIT_SAFE = 2'd2,
        ST_COMMIT    = 2'd3
    } state_e;

    // Power-on contents of both banks: a 60-2 wheel at 128 counts per tooth.
    function automatic logic [REG_W-1:0] reg_default(input int unsigned idx);
        logic [REG_W-1:0] val;
        case (idx)
            REG_MODE:      val = 16'h0017;
            REG_TOOTH_CNT: val = 16'd60;
            REG_TOOTH_W:   val = 16'd128;
            REG_MISSING:   val = 16'd2;
            REG_QPR:       val = 16'd7680;
            REG_PHASE_B:   val = 16'd2560;
            REG_PHASE_C:   val = 16'd5120;
            REG_TIMING:    val = 16'd427;
            REG_DWELL:     val = 16'd960;
            REG_INJ_A_PW:  val = 16'd2000;
            default:       val = 16'd0;
        endcase
        return val;
    endfunction

    function automatic logic [NUM_REGS*REG_W-1:0] default_bank();
        logic [NUM_REGS*REG_W-1:0] bank;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            bank[i*REG_W +: REG_W] = reg_default(i);
        end
        return bank;
    endfunction

endpackage

// File: rtl/cfg_geom_check.sv
// Combinational trigger-wheel geometry validator; reports the first failing rule.
module cfg_geom_check
    import efi_cfg_pkg::*;
(
    input  logic [15:0] tooth_cnt,
    input  logic [15:0] tooth_w,
    input  logic [15:0] missing,
    input  logic [15:0] qpr,
    output logic        ok,
    output logic [2:0]  code
);

    logic [31:0] rev_counts;

    assign rev_counts = 32'(tooth_cnt) * 32'(tooth_w);

    always_comb begin
        code = ERR_NONE;
        if (tooth_cnt == 16'd0 || qpr == 16'd0) begin
            code = ERR_ZERO;
        end else if (missing >= tooth_cnt) begin
            code = ERR_MISSING;
        end else if (rev_counts != 32'(qpr)) begin
            code = ERR_GEOM;
        end
        ok = (code == ERR_NONE);
    end

endmodule

// File: rtl/cfg_commit_ctrl.sv
// Double-buffered engine configuration: shadow bank written by SPI, copied
// atomically into the active bank at an engine-safe instant after validation.
module cfg_commit_ctrl
    import efi_cfg_pkg::*;
#(
    parameter int unsigned NREGS       = NUM_REGS,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [15:0]            wr_data,
    input  logic                   commit_req,
    input  logic                   abort,
    input  logic                   synced,
    input  logic                   trigger,
    input  logic [5:0]             outputs_busy,
    output logic [NREGS*16-1:0]    active_regs,
    output logic                   shadow_dirty,
    output logic                   commit_pending,
    output logic                   commit_done,
    output logic                   commit_err,
    output logic [2:0]             err_code
);

    localparam int unsigned BANK_W = NREGS * REG_W;
    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [BANK_W-1:0] DEF_BANK = BANK_W'(default_bank());

    state_e            state;
    state_e            state_nxt;
    logic [BANK_W-1:0] shadow;
    logic [CNT_W-1:0]  tmo_cnt;

    logic              geom_ok;
    logic [2:0]        geom_code;
    logic              safe;
    logic              tmo_hit;

    logic              do_copy;
    logic              set_err;
    logic              clr_err;
    err_code_e         err_nxt;

    cfg_geom_check u_geom (
        .tooth_cnt (shadow[REG_TOOTH_CNT*REG_W +: REG_W]),
        .tooth_w   (shadow[REG_TOOTH_W*REG_W +: REG_W]),
        .missing   (shadow[REG_MISSING*REG_W +: REG_W]),
        .qpr       (shadow[REG_QPR*REG_W +: REG_W]),
        .ok        (geom_ok),
        .code      (geom_code)
    );

    // A stopped engine is always safe; a running one only on an idle tooth edge.
    assign safe    = !synced || (trigger && (outputs_busy == 6'd0));
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (commit_req && !abort) state_nxt = ST_VALIDATE;
            end
            ST_VALIDATE: begin
                if (abort || !geom_ok) state_nxt = ST_IDLE;
                else                   state_nxt = ST_WAIT_SAFE;
            end
            ST_WAIT_SAFE: begin
                if (abort)        state_nxt = ST_IDLE;
                else if (safe)    state_nxt = ST_COMMIT;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-state strobes; abort outranks both validation and the safe window.
    always_comb begin
        do_copy = 1'b0;
        set_err = 1'b0;
        clr_err = 1'b0;
        err_nxt = ERR_NONE;
        unique case (state)
            ST_IDLE: begin
                clr_err = commit_req && !abort;
            end
            ST_VALIDATE: begin
                if (abort) begin
                    set_err = 1'b1;
                    err_nxt = ERR_ABORT;
                end else if (!geom_ok) begin
                    set_err = 1'b1;
                    err_nxt = err_code_e'(geom_code);
                end
            end
            ST_WAIT_SAFE: begin
                if (abort) begin
                    set_err = 1'b1;
                    err_nxt = ERR_ABORT;
                end else if (!safe && tmo_hit) begin
                    set_err = 1'b1;
                    err_nxt = ERR_TIMEOUT;
                end
            end
            ST_COMMIT: begin
                do_copy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT_SAFE) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Copy samples the pre-write shadow, so a write in the commit cycle stays dirty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow         <= DEF_BANK;
            active_regs    <= DEF_BANK;
            shadow_dirty   <= 1'b0;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
            commit_err     <= 1'b0;
            err_code       <= ERR_NONE;
        end else begin
            if (wr_en) begin
                shadow[int'(wr_addr)*REG_W +: REG_W] <= wr_data;
            end
            if (do_copy) begin
                active_regs <= shadow;
            end
            if (wr_en) begin
                shadow_dirty <= 1'b1;
            end else if (do_copy) begin
                shadow_dirty <= 1'b0;
            end
            commit_pending <= (state_nxt != ST_IDLE);
            commit_done    <= do_copy;
            if (set_err) begin
                commit_err <= 1'b1;
                err_code   <= err_nxt;
            end else if (clr_err) begin
                commit_err <= 1'b0;
                err_code   <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_cfg_commit_ctrl.sv
// Scoreboard bench for cfg_commit_ctrl: stimulus queues expected commit/error
// events, a negedge monitor pops and compares them as the DUT reports them.
module tb_cfg_commit_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [15:0]  wr_data;
    logic         commit_req;
    logic         abort;
    logic         synced;
    logic         trigger;
    logic [5:0]   outputs_busy;
    logic [255:0] active_regs;
    logic         shadow_dirty;
    logic         commit_pending;
    logic         commit_done;
    logic         commit_err;
    logic [2:0]   err_code;

    cfg_commit_ctrl #(.NREGS(16), .TIMEOUT_CYC(50)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .abort          (abort),
        .synced         (synced),
        .trigger        (trigger),
        .outputs_busy   (outputs_busy),
        .active_regs    (active_regs),
        .shadow_dirty   (shadow_dirty),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .commit_err     (commit_err),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_err;
        logic [2:0]   code;
        int           cyc;
        logic [255:0] bank;
        bit           dirty;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    bit  err_q = 1'b0;

    logic [15:0] def_r [16] = '{16'h0017, 16'd60, 16'd128, 16'd2, 16'd0, 16'd7680, 16'd0,
                                16'd2560, 16'd5120, 16'd0, 16'd427, 16'd960, 16'd2000,
                                16'd0, 16'd0, 16'd0};
    logic [15:0] sh [16];
    logic [15:0] act [16];
    bit          dirty_m;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] pack(input logic [15:0] r [16]);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = r[i];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: every commit_done pulse or rising commit_err must match the queue head.
    always @(negedge clk) begin
        bit ev_err;
        ev_t e;
        ev_err = commit_err && !err_q;
        err_q  = commit_err;
        if (rst_n === 1'b1 && (commit_done || ev_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: done=%0b err=%0b code=%0d at cycle %0d",
                         commit_done, commit_err, err_code, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind", 256'(ev_err), 256'(e.is_err));
                chk("err_code",   256'(err_code), 256'(e.code));
                chk("event_cycle", 256'(cyc), 256'(e.cyc));
                chk("active_bank", active_regs, e.bank);
                chk("shadow_dirty", 256'(shadow_dirty), 256'(e.dirty));
            end
        end
    end

    task automatic push(input bit is_err, input logic [2:0] code, input int lat,
                        input logic [255:0] bank, input bit dirty);
        ev_t e;
        e.is_err = is_err;
        e.code   = code;
        e.cyc    = cyc + lat;
        e.bank   = bank;
        e.dirty  = dirty;
        q.push_back(e);
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        sh[a]   = d;
        dirty_m = 1'b1;
    endtask

    task automatic req();
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL event_timeout: %0d expected events never seen", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic commit_ok();
        synced = 1'b0;
        push(1'b0, 3'd0, 4, pack(sh), 1'b0);
        req();
        act = sh;
        dirty_m = 1'b0;
        wait_empty();
    endtask

    task automatic commit_bad(input logic [2:0] code);
        push(1'b1, code, 2, pack(act), dirty_m);
        req();
        wait_empty();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit_req = 1'b0; abort = 1'b0; synced = 1'b0; trigger = 1'b0;
        outputs_busy = '0;
        sh = def_r; act = def_r; dirty_m = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        chk("reset_active", active_regs, pack(def_r));
        chk("reset_r1", 256'(active_regs[16 +: 16]), 256'd60);
        chk("reset_r5", 256'(active_regs[80 +: 16]), 256'd7680);
        chk("reset_r10", 256'(active_regs[160 +: 16]), 256'd427);
        chk("reset_pending", 256'(commit_pending), 256'd0);
        chk("reset_err_code", 256'(err_code), 256'd0);
        chk("reset_dirty", 256'(shadow_dirty), 256'd0);

        // Stopped engine: commit lands four cycles after the request.
        wr(10, 16'd500);
        chk("dirty_after_write", 256'(shadow_dirty), 256'd1);
        commit_ok();

        // Running engine: busy outputs block the tooth edge, idle ones allow it.
        synced = 1'b1;
        outputs_busy = 6'b000001;
        wr(11, 16'd1000);
        req();
        repeat (3) @(negedge clk);
        trigger = 1'b1; @(negedge clk); trigger = 1'b0;
        repeat (2) @(negedge clk);
        trigger = 1'b1; @(negedge clk); trigger = 1'b0;
        @(negedge clk);
        chk("pending_while_busy", 256'(commit_pending), 256'd1);
        outputs_busy = 6'b000000;
        push(1'b0, 3'd0, 2, pack(sh), 1'b0);
        trigger = 1'b1; @(negedge clk); trigger = 1'b0;
        act = sh;
        dirty_m = 1'b0;
        wait_empty();
        synced = 1'b0;

        // Validation errors leave the active bank untouched.
        wr(1, 16'd0);
        commit_bad(3'd1);
        chk("pending_after_err", 256'(commit_pending), 256'd0);
        wr(1, 16'd60);
        wr(3, 16'd60);
        commit_bad(3'd2);
        wr(3, 16'd2);
        wr(2, 16'd100);
        commit_bad(3'd3);
        wr(2, 16'd128);

        // No safe window on a running engine: timeout after 50 wait cycles.
        synced = 1'b1;
        push(1'b1, 3'd4, 52, pack(act), dirty_m);
        req();
        wait_empty();

        // Abort while waiting for the window.
        req();
        repeat (4) @(negedge clk);
        chk("pending_before_abort", 256'(commit_pending), 256'd1);
        push(1'b1, 3'd5, 1, pack(act), dirty_m);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        wait_empty();
        synced = 1'b0;

        // Request together with abort is dropped.
        commit_req = 1'b1; abort = 1'b1;
        @(negedge clk);
        commit_req = 1'b0; abort = 1'b0;
        repeat (6) @(negedge clk);
        chk("dropped_req_pending", 256'(commit_pending), 256'd0);

        // Write during the commit cycle: copy keeps the old r12, shadow keeps the new one.
        commit_ok();
        push(1'b0, 3'd0, 4, pack(sh), 1'b1);
        act = sh;
        req();
        repeat (2) @(negedge clk);
        wr(12, 16'd3000);
        wait_empty();
        chk("r12_old_in_active", 256'(active_regs[192 +: 16]), 256'd2000);
        commit_ok();
        chk("r12_new_committed", 256'(active_regs[192 +: 16]), 256'd3000);

        // Reset mid-commit restores every default.
        wr(10, 16'd777);
        synced = 1'b1;
        req();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sh = def_r; act = def_r; dirty_m = 1'b0;
        synced = 1'b0;
        @(negedge clk);
        chk("rst_mid_active", active_regs, pack(def_r));
        chk("rst_mid_pending", 256'(commit_pending), 256'd0);
        chk("rst_mid_dirty", 256'(shadow_dirty), 256'd0);
        chk("rst_mid_err", 256'({commit_err, err_code}), 256'd0);
        commit_ok();

        wait_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
